// File: rtl/wbs_ctrl_mc_if.sv
// Wishbone slave bus bundle for wbs_ctrl_mc: request fields from the master,
// ack/err/read-data back from the slave.
interface wbs_ctrl_mc_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic        wbs_err_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_err_o, wbs_dat_o
    );

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_err_o, wbs_dat_o
    );
endinterface

// File: rtl/wbs_ctrl_mc.sv
// Wishbone slave bridging 32-bit accesses onto NUM_CH wide memory channels,
// with a lane-merging write staging buffer and a small control register block.
module wbs_ctrl_mc #(
    parameter int NUM_CH = 4,
    parameter int MEM_DW = 64,
    parameter int MEM_AW = 6,
    parameter int RD_LAT = 1
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_ni,
    wbs_ctrl_mc_if.slave             bus,
    output logic                     wbs_mode,
    output logic                     wbs_debug,
    output logic [NUM_CH-1:0]        mem_csb,
    output logic [NUM_CH-1:0]        mem_web,
    output logic [MEM_AW-1:0]        mem_addr,
    output logic [MEM_DW-1:0]        mem_wdata,
    output logic [MEM_DW/8-1:0]      mem_wmask,
    input  logic [NUM_CH*MEM_DW-1:0] mem_rdata
);

    localparam int NL = MEM_DW / 32;
    localparam int LW = (NL > 1) ? $clog2(NL) : 1;
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int NB = MEM_DW / 8;
    localparam int TW = CW + MEM_AW;

    typedef enum logic [1:0] {IDLE, EXEC, RD_WAIT, RESP} state_t;

    state_t state, next_state;

    logic              we_q, err_q;
    logic [3:0]        sel_q;
    logic [31:0]       adr_q, dat_q, rd_data;
    logic [2:0]        rd_cnt;
    logic [15:0]       commit_cnt;
    logic [MEM_DW-1:0] stage_buf, merged_buf, rd_word;
    logic [NB-1:0]     stage_mask, merged_mask;
    logic [TW-1:0]     stage_tag, tag_new;
    logic [CW-1:0]     ch;
    logic [LW-1:0]     lane;
    logic [MEM_AW-1:0] maddr;
    logic              ctrl_q, last_lane, tag_hit, write_commit, rd_strobe;
    logic [31:0]       rd_lane;

    function automatic logic is_chan_f(input logic [31:0] adr);
        return (adr[31:24] >= 8'h31) && (adr[31:24] < 8'(8'h31 + NUM_CH));
    endfunction

    function automatic logic is_mapped_f(input logic [31:0] adr, input logic we);
        logic ctrl_ok;
        ctrl_ok = (adr[23:0] == 24'd0) || (adr[23:0] == 24'd1) ||
                  ((adr[23:0] == 24'd2) && !we);
        return is_chan_f(adr) || ((adr[31:24] == 8'h30) && ctrl_ok);
    endfunction

    assign ctrl_q       = (adr_q[31:24] == 8'h30);
    assign ch           = CW'(adr_q[31:24] - 8'h31);
    assign lane         = (NL > 1) ? adr_q[LW-1:0] : '0;
    assign maddr        = adr_q[LW+MEM_AW-1:LW];
    assign last_lane    = (lane == LW'(NL - 1));
    assign tag_new      = {ch, maddr};
    assign tag_hit      = (tag_new == stage_tag);
    assign write_commit = (state == EXEC) && !err_q && !ctrl_q && we_q && last_lane;
    assign rd_strobe    = (state == RD_WAIT) && (rd_cnt == 3'd0);
    assign rd_word      = mem_rdata[int'(ch)*MEM_DW +: MEM_DW];
    assign rd_lane      = rd_word[int'(lane)*32 +: 32];

    assign bus.wbs_ack_o = (state == RESP) && !err_q;
    assign bus.wbs_err_o = (state == RESP) && err_q;
    assign bus.wbs_dat_o = rd_data;

    // A write to a different {channel, address} starts a fresh mask
    always_comb begin
        merged_buf  = stage_buf;
        merged_mask = tag_hit ? stage_mask : '0;
        for (int b = 0; b < 4; b++) begin
            if (sel_q[b]) begin
                merged_buf[int'(lane)*32 + b*8 +: 8] = dat_q[b*8 +: 8];
                merged_mask[int'(lane)*4 + b]        = 1'b1;
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) state <= IDLE;
        else            state <= next_state;
    end

    // Unmapped accesses also pass through EXEC so every non-read response lands on the same cycle
    always_comb begin
        next_state = state;
        mem_csb    = '1;
        mem_web    = '1;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_wmask  = '0;
        case (state)
            IDLE: begin
                if (bus.wbs_cyc_i && bus.wbs_stb_i) begin
                    if (is_chan_f(bus.wbs_adr_i) && !bus.wbs_we_i) next_state = RD_WAIT;
                    else                                           next_state = EXEC;
                end
            end
            EXEC:    next_state = RESP;
            RD_WAIT: if (rd_cnt == 3'(RD_LAT)) next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if (write_commit) begin
            mem_csb[ch] = 1'b0;
            mem_web[ch] = 1'b0;
            mem_addr    = maddr;
            mem_wdata   = merged_buf;
            mem_wmask   = merged_mask;
        end else if (rd_strobe) begin
            mem_csb[ch] = 1'b0;
            mem_addr    = maddr;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            we_q       <= 1'b0;
            err_q      <= 1'b0;
            sel_q      <= '0;
            adr_q      <= '0;
            dat_q      <= '0;
            rd_cnt     <= '0;
            rd_data    <= '0;
            wbs_mode   <= 1'b0;
            wbs_debug  <= 1'b0;
            commit_cnt <= '0;
            stage_buf  <= '0;
            stage_mask <= '0;
            stage_tag  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    rd_cnt <= '0;
                    if (bus.wbs_cyc_i && bus.wbs_stb_i) begin
                        we_q  <= bus.wbs_we_i;
                        sel_q <= bus.wbs_sel_i;
                        adr_q <= bus.wbs_adr_i;
                        dat_q <= bus.wbs_dat_i;
                        err_q <= !is_mapped_f(bus.wbs_adr_i, bus.wbs_we_i);
                    end
                end
                EXEC: begin
                    if (!err_q && ctrl_q) begin
                        if (we_q) begin
                            if (adr_q[23:0] == 24'd0) wbs_mode  <= dat_q[0];
                            else                      wbs_debug <= dat_q[0];
                        end else begin
                            case (adr_q[1:0])
                                2'd0:    rd_data <= {31'd0, wbs_mode};
                                2'd1:    rd_data <= {31'd0, wbs_debug};
                                default: rd_data <= {16'd0, commit_cnt};
                            endcase
                        end
                    end else if (!err_q && we_q) begin
                        stage_buf <= merged_buf;
                        stage_tag <= tag_new;
                        if (last_lane) begin
                            stage_mask <= '0;
                            commit_cnt <= commit_cnt + 16'd1;
                        end else begin
                            stage_mask <= merged_mask;
                        end
                    end
                end
                RD_WAIT: begin
                    rd_cnt <= rd_cnt + 3'd1;
                    if (rd_cnt == 3'(RD_LAT)) rd_data <= rd_lane;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wbs_ctrl_mc.sv
// Scoreboard bench for wbs_ctrl_mc with two 64-bit channels and a one-cycle
// behavioural memory behind them.
module tb_wbs_ctrl_mc;

    localparam int NUM_CH = 2;
    localparam int MEM_DW = 64;
    localparam int MEM_AW = 6;
    localparam int RD_LAT = 1;

    typedef struct {
        logic        err;
        logic [31:0] dat;
        int          due;
    } resp_t;

    typedef struct {
        logic [1:0]  csb;
        logic [1:0]  web;
        logic [5:0]  addr;
        logic [63:0] wdata;
        logic [7:0]  wmask;
    } strobe_t;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     mode, debug;
    logic [NUM_CH-1:0]        mem_csb, mem_web;
    logic [MEM_AW-1:0]        mem_addr;
    logic [MEM_DW-1:0]        mem_wdata;
    logic [MEM_DW/8-1:0]      mem_wmask;
    logic [NUM_CH*MEM_DW-1:0] mem_rdata;
    logic [63:0]              mem [NUM_CH][64];
    logic [63:0]              rdata_q [NUM_CH];

    resp_t       resp_q[$];
    strobe_t     strobe_q[$];
    int          tests_run = 0;
    int          tests_failed = 0;
    int          cyc_cnt = 0;
    logic [31:0] last_rd = 32'd0;

    wbs_ctrl_mc_if bus();

    wbs_ctrl_mc #(.NUM_CH(NUM_CH), .MEM_DW(MEM_DW), .MEM_AW(MEM_AW), .RD_LAT(RD_LAT)) dut (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
        .bus       (bus),
        .wbs_mode  (mode),
        .wbs_debug (debug),
        .mem_csb   (mem_csb),
        .mem_web   (mem_web),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wmask (mem_wmask),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Synchronous memory: byte-masked writes, registered reads one cycle after the strobe
    always @(posedge clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (!mem_csb[c]) begin
                if (!mem_web[c]) begin
                    for (int b = 0; b < 8; b++)
                        if (mem_wmask[b]) mem[c][mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
                end else begin
                    rdata_q[c] <= mem[c][mem_addr];
                end
            end
        end
    end

    assign mem_rdata = {rdata_q[1], rdata_q[0]};

    function automatic logic [63:0] expand(input logic [7:0] m);
        logic [63:0] r;
        for (int b = 0; b < 8; b++) r[b*8 +: 8] = {8{m[b]}};
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Pops the response and strobe scoreboards as the DUT produces them
    always @(negedge clk) begin
        resp_t   e;
        strobe_t s;
        if (rst_n) begin
            checkOutput("ack_err_exclusive", 64'(bus.wbs_ack_o & bus.wbs_err_o), 64'd0);
            if (bus.wbs_ack_o || bus.wbs_err_o) begin
                if (resp_q.size() == 0) begin
                    checkOutput("unexpected_resp", {62'd0, bus.wbs_ack_o, bus.wbs_err_o}, 64'd0);
                end else begin
                    e = resp_q.pop_front();
                    checkOutput("resp_err", 64'(bus.wbs_err_o), 64'(e.err));
                    checkOutput("resp_ack", 64'(bus.wbs_ack_o), 64'(!e.err));
                    checkOutput("resp_latency", 64'(cyc_cnt), 64'(e.due));
                    checkOutput("resp_dat", 64'(bus.wbs_dat_o), 64'(e.dat));
                end
            end
            if (mem_csb != 2'b11) begin
                if (strobe_q.size() == 0) begin
                    checkOutput("unexpected_strobe", 64'(mem_csb), 64'h3);
                end else begin
                    s = strobe_q.pop_front();
                    checkOutput("strobe_csb", 64'(mem_csb), 64'(s.csb));
                    checkOutput("strobe_web", 64'(mem_web), 64'(s.web));
                    checkOutput("strobe_addr", 64'(mem_addr), 64'(s.addr));
                    checkOutput("strobe_wmask", 64'(mem_wmask), 64'(s.wmask));
                    checkOutput("strobe_wdata", mem_wdata & expand(s.wmask), s.wdata & expand(s.wmask));
                end
            end else begin
                checkOutput("idle_web", 64'(mem_web), 64'h3);
                checkOutput("idle_bus_zero", 64'(|{mem_addr, mem_wdata, mem_wmask}), 64'd0);
            end
        end
    end

    task automatic expectStrobe(input logic [1:0] csb, input logic [1:0] web, input logic [5:0] addr,
                                input logic [63:0] wdata, input logic [7:0] wmask);
        strobe_t s;
        s.csb = csb; s.web = web; s.addr = addr; s.wdata = wdata; s.wmask = wmask;
        strobe_q.push_back(s);
    endtask

    // One-cycle request pulse, then wait (bounded) for the scoreboard to drain
    task automatic applyStimulus(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                                 input logic [3:0] sel, input logic exp_err,
                                 input logic [31:0] exp_rd, input int lat);
        resp_t e;
        @(negedge clk);
        if (!we && !exp_err) last_rd = exp_rd;
        e.err = exp_err;
        e.dat = last_rd;
        e.due = cyc_cnt + lat;
        resp_q.push_back(e);
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_we_i  = we;
        bus.wbs_adr_i = adr;
        bus.wbs_dat_i = dat;
        bus.wbs_sel_i = sel;
        @(negedge clk);
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (resp_q.size() == 0) break;
            @(negedge clk);
            #1;
        end
        if (resp_q.size() != 0) begin
            checkOutput("resp_timeout", 64'(resp_q.size()), 64'd0);
            resp_q.delete();
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
        bus.wbs_sel_i = 4'h0;
        bus.wbs_adr_i = 32'h0;
        bus.wbs_dat_i = 32'h0;
        repeat (3) @(negedge clk);
        checkOutput("rst_ack", 64'(bus.wbs_ack_o), 64'd0);
        checkOutput("rst_err", 64'(bus.wbs_err_o), 64'd0);
        checkOutput("rst_dat", 64'(bus.wbs_dat_o), 64'd0);
        checkOutput("rst_mode_debug", {62'd0, mode, debug}, 64'd0);
        checkOutput("rst_csb_web", {60'd0, mem_csb, mem_web}, 64'hF);
        rst_n = 1'b1;

        applyStimulus(1'b0, 32'h3000_0002, 32'h0, 4'hF, 1'b0, 32'd0, 2);

        // Two lanes of ch0 addr 2 committed as one word
        applyStimulus(1'b1, 32'h3100_0004, 32'h1111_2222, 4'hF, 1'b0, 32'd0, 2);
        expectStrobe(2'b10, 2'b10, 6'd2, 64'h3333_4444_1111_2222, 8'hFF);
        applyStimulus(1'b1, 32'h3100_0005, 32'h3333_4444, 4'hF, 1'b0, 32'd0, 2);
        applyStimulus(1'b0, 32'h3000_0002, 32'h0, 4'hF, 1'b0, 32'd1, 2);
        expectStrobe(2'b10, 2'b11, 6'd2, 64'd0, 8'h00);
        applyStimulus(1'b0, 32'h3100_0004, 32'h0, 4'hF, 1'b0, 32'h1111_2222, 2 + RD_LAT);

        // Fill ch1 addr 1, then read the upper lane back
        applyStimulus(1'b1, 32'h3200_0002, 32'hCCCC_DDDD, 4'hF, 1'b0, 32'd0, 2);
        expectStrobe(2'b01, 2'b01, 6'd1, 64'hAAAA_BBBB_CCCC_DDDD, 8'hFF);
        applyStimulus(1'b1, 32'h3200_0003, 32'hAAAA_BBBB, 4'hF, 1'b0, 32'd0, 2);
        expectStrobe(2'b01, 2'b11, 6'd1, 64'd0, 8'h00);
        applyStimulus(1'b0, 32'h3200_0003, 32'h0, 4'hF, 1'b0, 32'hAAAA_BBBB, 2 + RD_LAT);
        expectStrobe(2'b01, 2'b11, 6'd1, 64'd0, 8'h00);
        applyStimulus(1'b0, 32'h3200_0002, 32'h0, 4'hF, 1'b0, 32'hCCCC_DDDD, 2 + RD_LAT);

        // Partial lane 0 on addr 0 is dropped when lane 1 of addr 1 retags
        applyStimulus(1'b1, 32'h3100_0000, 32'hDEAD_BEEF, 4'b0011, 1'b0, 32'd0, 2);
        expectStrobe(2'b10, 2'b10, 6'd1, 64'hCAFE_F00D_0000_0000, 8'hF0);
        applyStimulus(1'b1, 32'h3100_0003, 32'hCAFE_F00D, 4'hF, 1'b0, 32'd0, 2);

        // A read between the two halves leaves the staged lane intact
        applyStimulus(1'b1, 32'h3100_000E, 32'h0123_4567, 4'hF, 1'b0, 32'd0, 2);
        expectStrobe(2'b01, 2'b11, 6'd1, 64'd0, 8'h00);
        applyStimulus(1'b0, 32'h3200_0003, 32'h0, 4'hF, 1'b0, 32'hAAAA_BBBB, 2 + RD_LAT);
        expectStrobe(2'b10, 2'b10, 6'd7, 64'h89AB_CDEF_0123_4567, 8'hCF);
        applyStimulus(1'b1, 32'h3100_000F, 32'h89AB_CDEF, 4'b1100, 1'b0, 32'd0, 2);

        // Commit with nothing selected still strobes, mask zero
        expectStrobe(2'b10, 2'b10, 6'd5, 64'd0, 8'h00);
        applyStimulus(1'b1, 32'h3100_000B, 32'hFFFF_FFFF, 4'h0, 1'b0, 32'd0, 2);
        applyStimulus(1'b0, 32'h3000_0002, 32'h0, 4'hF, 1'b0, 32'd5, 2);

        // Unmapped regions and the read-only counter
        applyStimulus(1'b0, 32'h3300_0000, 32'h0, 4'hF, 1'b1, 32'd0, 2);
        applyStimulus(1'b1, 32'h3000_0002, 32'h1234, 4'hF, 1'b1, 32'd0, 2);
        applyStimulus(1'b1, 32'h3000_0003, 32'h1, 4'hF, 1'b1, 32'd0, 2);
        applyStimulus(1'b1, 32'h2F00_0000, 32'h1, 4'hF, 1'b1, 32'd0, 2);
        applyStimulus(1'b0, 32'h3000_0002, 32'h0, 4'hF, 1'b0, 32'd5, 2);

        applyStimulus(1'b1, 32'h3000_0000, 32'h1, 4'hF, 1'b0, 32'd0, 2);
        checkOutput("mode_set", 64'(mode), 64'd1);
        applyStimulus(1'b0, 32'h3000_0000, 32'h0, 4'hF, 1'b0, 32'd1, 2);
        applyStimulus(1'b1, 32'h3000_0001, 32'h3, 4'hF, 1'b0, 32'd0, 2);
        checkOutput("debug_set", 64'(debug), 64'd1);
        applyStimulus(1'b0, 32'h3000_0001, 32'h0, 4'hF, 1'b0, 32'd1, 2);

        // Reset while a channel read waits on memory
        expectStrobe(2'b10, 2'b11, 6'd2, 64'd0, 8'h00);
        @(negedge clk);
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_we_i  = 1'b0;
        bus.wbs_adr_i = 32'h3100_0004;
        @(negedge clk);
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("abort_mode_debug", {62'd0, mode, debug}, 64'd0);
        checkOutput("abort_ack_err", {62'd0, bus.wbs_ack_o, bus.wbs_err_o}, 64'd0);
        checkOutput("abort_dat", 64'(bus.wbs_dat_o), 64'd0);
        checkOutput("abort_csb_web", {60'd0, mem_csb, mem_web}, 64'hF);
        last_rd = 32'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        applyStimulus(1'b0, 32'h3000_0002, 32'h0, 4'hF, 1'b0, 32'd0, 2);
        applyStimulus(1'b0, 32'h3000_0000, 32'h0, 4'hF, 1'b0, 32'd0, 2);

        repeat (2) @(negedge clk);
        checkOutput("strobe_q_drained", 64'(strobe_q.size()), 64'd0);
        checkOutput("resp_q_drained", 64'(resp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
